// File: rtl/lane_engine.sv
`timescale 1ns/1ps
`default_nettype none
// lane_engine: scrolling obstacle lanes with a registered pixel colour and a
// per-frame sequential frog/obstacle collision scan, one (lane, object) pair per cycle.
module lane_engine #(
  parameter int NUM_LANES    = 4,
  parameter int OBJ_PER_LANE = 2,
  parameter int OBJ_WIDTH    = 64,
  parameter int LANE_HEIGHT  = 32,
  parameter int LANE_Y0      = 64,
  parameter int SCREEN_W     = 640,
  parameter logic [5:0] OBJ_COLOR = 6'b110000,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic                   enable,
  input  logic [NUM_LANES*3-1:0] speed_cfg,
  input  logic [NUM_LANES-1:0]   dir_cfg,
  input  logic [9:0]             colPos,
  input  logic [9:0]             rowPos,
  input  logic [9:0]             frog_x,
  input  logic [9:0]             frog_y,
  input  logic [5:0]             frog_size,
  output logic [5:0]             color,
  output logic                   collision,
  output logic [LW-1:0]          hit_lane
);
  localparam int NPAIR = NUM_LANES * OBJ_PER_LANE;
  localparam int IW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [10:0]   W11     = 11'(SCREEN_W);
  localparam logic [10:0]   OW11    = 11'(OBJ_WIDTH);
  localparam logic [10:0]   SPACING = 11'(SCREEN_W / OBJ_PER_LANE);
  localparam logic [IW-1:0] LAST    = IW'(NPAIR - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic [9:0]       off    [NUM_LANES];
  logic [9:0]       off_nx [NUM_LANES];
  logic [10:0]      obj_x  [NPAIR];
  logic [NPAIR-1:0] pair_hit;
  logic             pix_on;
  logic [IW-1:0]    idx;
  logic             hit_any;
  logic [LW-1:0]    hit_lane_lat;
  logic [LW-1:0]    lane_of_idx;
  logic [10:0]      spd, cur, sum, st, y_lo, y_hi;
  logic [10:0]      fx, fx_end, fy, fy_end, px, py;

  // All extents are 11 bits so a frog past the right edge or row 479 never wraps.
  assign fx     = {1'b0, frog_x};
  assign fx_end = fx + {5'd0, frog_size};
  assign fy     = {1'b0, frog_y};
  assign fy_end = fy + {5'd0, frog_size};
  assign px     = {1'b0, colPos};
  assign py     = {1'b0, rowPos};
  assign lane_of_idx = LW'(int'(idx) / OBJ_PER_LANE);

  // Overlap of [lo,hi) with an obstacle starting at st; a wrapped obstacle is two segments.
  function automatic logic seg_hit(input logic [10:0] s, input logic [10:0] lo,
                                   input logic [10:0] hi);
    logic [10:0] en;
    en = s + OW11;
    if (en > W11) seg_hit = ((lo < W11) && (s < hi)) || (lo < (en - W11));
    else          seg_hit = (lo < en) && (s < hi);
  endfunction

  always_comb begin
    spd = '0;
    cur = '0;
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      spd = {8'd0, speed_cfg[3*i +: 3]};
      cur = {1'b0, off[i]};
      if (dir_cfg[i]) begin
        sum = cur + spd;
        if (sum >= W11) sum = sum - W11;
      end else if (cur >= spd) begin
        sum = cur - spd;
      end else begin
        sum = cur + W11 - spd;
      end
      off_nx[i] = sum[9:0];
    end
  end

  always_comb begin
    st = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int k = 0; k < OBJ_PER_LANE; k++) begin
        st = {1'b0, off[i]} + 11'(k) * SPACING;
        if (st >= W11) st = st - W11;
        obj_x[i*OBJ_PER_LANE + k] = st;
      end
    end
  end

  always_comb begin
    pix_on   = 1'b0;
    pair_hit = '0;
    y_lo     = '0;
    y_hi     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      y_lo = 11'(LANE_Y0 + i * LANE_HEIGHT);
      y_hi = y_lo + 11'(LANE_HEIGHT);
      for (int k = 0; k < OBJ_PER_LANE; k++) begin
        if ((py >= y_lo) && (py < y_hi) && seg_hit(obj_x[i*OBJ_PER_LANE + k], px, px + 11'd1))
          pix_on = 1'b1;
        if ((frog_size != 6'd0) && (fy < y_hi) && (y_lo < fy_end) &&
            seg_hit(obj_x[i*OBJ_PER_LANE + k], fx, fx_end))
          pair_hit[i*OBJ_PER_LANE + k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) off[i] <= '0;
    end else if (frame_tick && enable) begin
      for (int i = 0; i < NUM_LANES; i++) off[i] <= off_nx[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A tick in any state restarts the scan, which silently drops a partial result.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_tick) state_nx = SCAN;
      SCAN:    if (frame_tick) state_nx = SCAN;
               else if (idx == LAST) state_nx = DONE;
      DONE:    state_nx = frame_tick ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      hit_any      <= 1'b0;
      hit_lane_lat <= '0;
      collision    <= 1'b0;
      hit_lane     <= '0;
      color        <= '0;
    end else begin
      color     <= pix_on ? OBJ_COLOR : 6'd0;
      collision <= (state == DONE) && !frame_tick && hit_any;
      if (frame_tick) begin
        idx          <= '0;
        hit_any      <= 1'b0;
        hit_lane_lat <= '0;
      end else if (state == SCAN) begin
        if (idx != LAST) idx <= idx + 1'b1;
        // Lane-major scan order makes the first hit the lowest-indexed lane.
        if (pair_hit[idx] && !hit_any) begin
          hit_any      <= 1'b1;
          hit_lane_lat <= lane_of_idx;
        end
      end
      if ((state == DONE) && !frame_tick) hit_lane <= hit_any ? hit_lane_lat : '0;
    end
  end

endmodule
`default_nettype wire
